stack_responder: RTL

//   Operand stack serving the control unit's stack strobe interface. Detects rising

---
 rtl/stack_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/stack_responder.sv
// Operand stack behind the control unit's stack strobe: one push or pop per
// rising edge of req_i, with top-of-stack, popped data and sticky error status.
module stack_responder #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_i,
  input  logic             wren_i,
  input  logic             src_sel_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic [WIDTH-1:0] alu_in_i,
  input  logic             clr_flags_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic [WIDTH-1:0] tos_o,
  output logic [CW-1:0]    count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o,
  output logic             underflow_o,
  output logic             collision_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             req_q;
  logic             start;
  logic             op_wren_q, op_wren_d;
  logic [WIDTH-1:0] op_word_q, op_word_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             col_q, col_d;
  logic             set_ovf, set_unf, set_col;
  logic             mem_we;
  logic             full, empty;
  logic [AW-1:0]    wr_ptr, top_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign start   = req_i & ~req_q;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_ptr  = AW'(count_q);
  assign top_ptr = AW'(count_q - CW'(1));

  always_comb begin
    state_d    = state_q;
    op_wren_d  = op_wren_q;
    op_word_d  = op_word_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    mem_we     = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_wren_d = wren_i;
          op_word_d = src_sel_i ? alu_in_i : data_in_i;
          state_d   = S_OP;
        end
      end
      S_OP: begin
        if (op_wren_q) begin
          if (!full) begin
            mem_we  = 1'b1;
            count_d = count_q + CW'(1);
          end else begin
            set_ovf = 1'b1;
          end
        end else begin
          if (!empty) begin
            data_out_d = mem[top_ptr];
            count_d    = count_q - CW'(1);
          end else begin
            set_unf = 1'b1;
          end
        end
        state_d = S_ACK;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A new edge while an op is in flight is consumed and only flagged.
  assign set_col = start & (state_q != S_IDLE);
  assign ovf_d   = set_ovf | (ovf_q & ~clr_flags_i);
  assign unf_d   = set_unf | (unf_q & ~clr_flags_i);
  assign col_d   = set_col | (col_q & ~clr_flags_i);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      op_wren_q  <= 1'b0;
      op_word_q  <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      col_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_i;
      op_wren_q  <= op_wren_d;
      op_word_q  <= op_word_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      col_q      <= col_d;
    end
  end

  // Storage is deliberately left out of reset; tos masks it while empty.
  always_ff @(posedge clock) begin
    if (mem_we) mem[wr_ptr] <= op_word_q;
  end

  assign data_out_o  = data_out_q;
  assign tos_o       = empty ? '0 : mem[top_ptr];
  assign count_o     = count_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_ACK);
  assign full_o      = full;
  assign empty_o     = empty;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign collision_o = col_q;

endmodule
